// File: rtl/seq_shifter_if.sv
// seq_shifter_if: request/result handshake bundle for the multi-cycle shifter
`timescale 1ns/1ps
interface seq_shifter_if #(
  parameter int n = 32
);
  localparam int SHW = $clog2(n);
  logic           in_valid;
  logic           in_ready;
  logic [n-1:0]   in_data;
  logic [SHW-1:0] in_shamt;
  logic [1:0]     in_mode;
  logic           out_valid;
  logic           out_ready;
  logic [n-1:0]   out_data;
  logic           out_overflow;
  logic           busy;
  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, busy
  );
  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_overflow, busy
  );
endinterface

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle SLL/SRL/SRA/ROL unit moving at most STEP bits per cycle
`timescale 1ns/1ps
module seq_shifter #(
  parameter int n    = 32,
  parameter int STEP = 4
) (
  input logic           clk,
  input logic           reset,
  seq_shifter_if.slave  bus
);
  localparam int SHW = $clog2(n);
  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROL = 2'b11;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t         state_q, state_d;
  logic [n-1:0]   data_q, data_d;
  logic [1:0]     mode_q, mode_d;
  logic [SHW-1:0] rem_q, rem_d;
  logic           ovf_q, ovf_d;
  logic [SHW:0]   rem_ext, k, nk;
  logic [n-1:0]   sll, srl, sra, rol, spill, step_res;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      mode_q  <= SLL;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end
  // SRA keeps data_q's MSB equal to the original sign, so it doubles as the fill bit
  always_comb begin
    rem_ext  = {1'b0, rem_q};
    k        = rem_ext < (SHW+1)'(STEP) ? rem_ext : (SHW+1)'(STEP);
    nk       = (SHW+1)'(n) - k;
    sll      = data_q << k;
    srl      = data_q >> k;
    sra      = srl | (data_q[n-1] ? ~({n{1'b1}} >> k) : '0);
    spill    = data_q >> nk;
    rol      = sll | spill;
    step_res = mode_q == SLL ? sll : mode_q == SRL ? srl : mode_q == SRA ? sra : rol;
  end
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: if (bus.in_valid && bus.in_ready) begin
        data_d  = bus.in_data;
        mode_d  = bus.in_mode;
        rem_d   = bus.in_shamt;
        ovf_d   = 1'b0;
        state_d = bus.in_shamt == '0 ? DONE : BUSY;
      end
      BUSY: begin
        data_d  = step_res;
        ovf_d   = ovf_q | (mode_q == SLL && |spill);
        rem_d   = rem_q - k[SHW-1:0];
        state_d = rem_d == '0 ? DONE : BUSY;
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready     = state_q == IDLE && !reset;
    bus.out_valid    = state_q == DONE;
    bus.busy         = state_q != IDLE;
    bus.out_data     = data_q;
    bus.out_overflow = ovf_q;
  end
endmodule
